// File: rtl/trace_buffer.sv
// Instruction trace capture buffer: records committed-instruction tuples, triggers on a PC
// match, then drains oldest-first. Define TRACE_RESULT_EN to store and return cap_result.
module trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int POST   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       wrap_mode,
  input  logic                       trig_en,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          cap_pc,
  input  logic [DATA_W-1:0]          cap_instr,
  input  logic [DATA_W-1:0]          cap_result,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_instr,
  output logic [DATA_W-1:0]          rd_result,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] POST_CNT = CW'(POST);

  // Readout handshake: a record transfers on a rising edge where rd_valid && rd_ready;
  // rd_valid is only ever high in DONE and rd_ready is ignored in every other state.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   post_cnt_q, post_cnt_d;
  logic            overflow_q, overflow_d;

  logic            wr_en;
  logic            full;
  logic            trig_hit;
  logic            fill_stop;

  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    full       = (count_q == FULL_CNT);
    trig_hit   = 1'b0;
    fill_stop  = 1'b0;

    if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED, S_POST: begin
          if (cap_valid) begin
            if (!full) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
              count_d  = count_q + CW'(1);
            end else if (wrap_mode) begin
              // Full circular buffer: overwrite the oldest slot and drop it from the read side.
              wr_en      = 1'b1;
              wr_ptr_d   = wr_ptr_q + PW'(1);
              rd_ptr_d   = rd_ptr_q + PW'(1);
              overflow_d = 1'b1;
            end
          end
          fill_stop = wr_en && !wrap_mode && (count_d == FULL_CNT);
          trig_hit  = (state_q == S_ARMED) && trig_en && cap_valid && (cap_pc == trig_pc);

          if (state_q == S_ARMED) begin
            if (stop || fill_stop) begin
              state_d = S_DONE;
            end else if (trig_hit) begin
              post_cnt_d = CW'(1);
              state_d    = (POST == 1) ? S_DONE : S_POST;
            end
          end else if (cap_valid) begin
            post_cnt_d = post_cnt_q + CW'(1);
            if ((post_cnt_d == POST_CNT) || fill_stop) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (count_q == '0) begin
            state_d = S_IDLE;
          end else if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; only the pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= cap_pc;
      instr_mem[wr_ptr_q] <= cap_instr;
    end
  end

`ifdef TRACE_RESULT_EN
  logic [DATA_W-1:0] result_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      result_mem[wr_ptr_q] <= cap_result;
    end
  end

  assign rd_result = result_mem[rd_ptr_q];
`else
  logic unused_cap_result;
  assign unused_cap_result = ^cap_result;
  assign rd_result = '0;
`endif

  assign rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign rd_pc    = pc_mem[rd_ptr_q];
  assign rd_instr = instr_mem[rd_ptr_q];
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized traffic, checked
// against a queue-based reference model sampled on the falling clock edge.
module tb_trace_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int POST   = 8;
  localparam int RW     = 3 * DATA_W;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic              stop;
  logic              wrap_mode;
  logic              trig_en;
  logic [DATA_W-1:0] trig_pc;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_pc;
  logic [DATA_W-1:0] cap_instr;
  logic [DATA_W-1:0] cap_result;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic [DATA_W-1:0] rd_result;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]        state;
  logic              overflow;

  trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .wrap_mode(wrap_mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_result(cap_result), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .count(count), .state(state), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the records the buffer should contain, oldest at the front.
  logic [RW-1:0] exp_q[$];
  int            m_state = 0;
  int            m_post  = 0;
  logic          m_ovf   = 1'b0;
  logic [RW-1:0] rec;
  logic [DATA_W-1:0] res_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_state = 0;
      m_post  = 0;
      m_ovf   = 1'b0;
    end else begin
      check("state", {30'd0, state}, m_state);
      check("count", {27'd0, count}, exp_q.size());
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("rd_valid", {31'd0, rd_valid}, {31'd0, (m_state == 3 && exp_q.size() != 0)});
      if (m_state == 3 && exp_q.size() != 0) begin
        rec = exp_q[0];
        check("rd_pc", rd_pc, rec[3*DATA_W-1:2*DATA_W]);
        check("rd_instr", rd_instr, rec[2*DATA_W-1:DATA_W]);
        check("rd_result", rd_result, rec[DATA_W-1:0]);
      end

      if (arm) begin
        exp_q.delete();
        m_state = 1;
        m_post  = 0;
        m_ovf   = 1'b0;
      end else if (m_state == 1 || m_state == 2) begin
`ifdef TRACE_RESULT_EN
        res_exp = cap_result;
`else
        res_exp = '0;
`endif
        if (cap_valid) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back({cap_pc, cap_instr, res_exp});
          end else if (wrap_mode) begin
            void'(exp_q.pop_front());
            exp_q.push_back({cap_pc, cap_instr, res_exp});
            m_ovf = 1'b1;
          end
        end
        if (m_state == 1) begin
          if (stop) m_state = 3;
          else if (cap_valid && !wrap_mode && exp_q.size() == DEPTH) m_state = 3;
          else if (trig_en && cap_valid && cap_pc == trig_pc) begin
            m_post  = 1;
            m_state = (POST == 1) ? 3 : 2;
          end
        end else if (cap_valid) begin
          m_post++;
          if (m_post == POST || (!wrap_mode && exp_q.size() == DEPTH)) m_state = 3;
        end
      end else if (m_state == 3) begin
        if (exp_q.size() == 0) m_state = 0;
        else if (rd_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_state = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic a, input logic s, input logic cv,
                       input logic [DATA_W-1:0] p, input logic rdy);
    @(posedge clk);
    #1;
    arm        = a;
    stop       = s;
    cap_valid  = cv;
    cap_pc     = p;
    cap_instr  = $urandom;
    cap_result = $urandom;
    rd_ready   = rdy;
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (state != 2'd0 && n < 300) begin
      drive(1'b0, 1'b0, 1'b0, '0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    check("drain_reaches_idle", {30'd0, state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; arm = 1'b0; stop = 1'b0; wrap_mode = 1'b0; trig_en = 1'b0;
    trig_pc = '0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_result = '0;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Fill without trigger, stop-when-full.
    wrap_mode = 1'b0; trig_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, DATA_W'(i), 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drain(1'b0);

    // Circular overwrite then stop.
    wrap_mode = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, DATA_W'(i), 1'b0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drain(1'b0);

    // PC trigger at 0x40 with POST records.
    wrap_mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h40;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b0, 1'b1, DATA_W'(4 * i), 1'b0);
    drain(1'b1);

    // Back-pressure, then arm colliding with a pop, then empty DONE.
    wrap_mode = 1'b0; trig_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, DATA_W'(32'h100 + i), 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset while in POST after three captures.
    wrap_mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h40;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h48, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", {30'd0, state}, 32'd0);
    check("async_reset_count", {27'd0, count}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic a;
      a = ($urandom_range(0, 99) < 2) || (state == 2'd0 && $urandom_range(0, 7) == 0);
      if (a) begin
        @(posedge clk);
        #1;
        wrap_mode = 1'($urandom_range(0, 1));
        trig_en   = 1'($urandom_range(0, 1));
        trig_pc   = DATA_W'(4 * $urandom_range(0, 31));
        arm = 1'b1; stop = 1'b0; cap_valid = 1'b0; rd_ready = 1'($urandom_range(0, 1));
      end else begin
        drive(1'b0, 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 70),
              DATA_W'(4 * $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drain(1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
